// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: sync byte,
// FSM state encoding and error codes.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CHK     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; emits a registered
// word with a one-cycle valid the cycle after the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;
  logic        word_vld_q;
  logic [31:0] word_q;

  assign last_byte_o = en_i && (byte_idx_q == 2'd3);
  assign word_vld_o  = word_vld_q;
  assign word_o      = word_q;

  // Earlier bytes enter at the top and drift down, so byte 0 ends in [7:0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
      word_vld_q <= 1'b0;
      word_q     <= '0;
    end else begin
      word_vld_q <= last_byte_o;
      if (clear_i) begin
        byte_idx_q <= '0;
      end else if (en_i) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        if (last_byte_o) begin
          word_q <= {byte_i, shift_q};
        end else begin
          shift_q <= {byte_i, shift_q[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: frames A5/LEN/payload/XOR-checksum, writes words
// into instruction memory and holds the core in reset while loading.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int              DEPTH   = 2 ** ADDR_WIDTH;
  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     DEPTH_L = 17'(DEPTH);

  state_e                state_q;
  logic [7:0]            len_lo_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic [ADDR_WIDTH:0]   word_idx_d;
  logic [7:0]            chk_q;
  logic [TW-1:0]         tmo_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  hold_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [1:0]            err_code_q;

  logic [15:0] len_d;
  logic        len_bad;
  logic        in_frame;
  logic        sync_hit;
  logic        tmo_hit;
  logic        pk_en;
  logic        pk_last;
  logic        pk_vld;
  logic [31:0] pk_word;

  always_comb begin
    len_d      = {rx_data, len_lo_q};
    len_bad    = (len_d == 16'd0) || ({1'b0, len_d} > DEPTH_L);
    word_idx_d = word_idx_q + 1'b1;
    in_frame   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                 (state_q == ST_DATA)   || (state_q == ST_CHK);
    sync_hit   = rx_valid && (rx_data == SYNC_BYTE) &&
                 ((state_q == ST_IDLE) || (state_q == ST_ERR));
    // A byte arriving on the expiry cycle takes priority over the timeout.
    tmo_hit    = in_frame && !rx_valid && (tmo_q == TO_LAST);
    pk_en      = (state_q == ST_DATA) && rx_valid;
  end

  byte_word_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (sync_hit),
    .en_i        (pk_en),
    .byte_i      (rx_data),
    .last_byte_o (pk_last),
    .word_vld_o  (pk_vld),
    .word_o      (pk_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      tmo_q      <= '0;
      waddr_q    <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      if (pk_last) begin
        waddr_q <= word_idx_q[ADDR_WIDTH-1:0];
      end
      if (in_frame && !rx_valid) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end

      if (tmo_hit) begin
        state_q    <= ST_ERR;
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_ERR: begin
            if (sync_hit) begin
              state_q    <= ST_LEN_LO;
              err_q      <= 1'b0;
              err_code_q <= ERR_NONE;
              chk_q      <= '0;
              word_idx_q <= '0;
              busy_q     <= 1'b1;
              hold_q     <= 1'b1;
            end
          end
          ST_LEN_LO: begin
            if (rx_valid) begin
              len_lo_q <= rx_data;
              state_q  <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (rx_valid) begin
              if (len_bad) begin
                state_q    <= ST_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_LEN;
                busy_q     <= 1'b0;
              end else begin
                len_q   <= len_d[ADDR_WIDTH:0];
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              chk_q <= chk_q ^ rx_data;
              if (pk_last) begin
                word_idx_q <= word_idx_d;
                if (word_idx_d == len_q) begin
                  state_q <= ST_CHK;
                end
              end
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data == chk_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= ST_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_CHK;
                busy_q     <= 1'b0;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_we         = pk_vld;
  assign mem_waddr      = waddr_q;
  assign mem_wdata      = pk_word;
  assign cpu_reset_hold = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes and
// frame outcomes; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int TMO   = 50;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TMO)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .cpu_reset_hold (cpu_reset_hold),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit is_err; logic [1:0] code; } ev_t;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_wr[$];
  ev_t         exp_ev[$];
  wr_t         w_pop;
  ev_t         e_pop;
  logic [AW-1:0] last_addr = '0;
  logic [31:0] last_data = '0;
  bit          err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write and every done/err event must match the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", mem_waddr, mem_wdata);
        end else begin
          w_pop = exp_wr.pop_front();
          check("wr_addr", 32'(mem_waddr), 32'(w_pop.addr));
          check("wr_data", mem_wdata, w_pop.data);
          last_addr = w_pop.addr;
          last_data = w_pop.data;
        end
      end else begin
        check("waddr_hold", 32'(mem_waddr), 32'(last_addr));
        check("wdata_hold", mem_wdata, last_data);
      end
      if (done) begin
        if (exp_ev.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected no event");
        end else begin
          e_pop = exp_ev.pop_front();
          check("done_event_kind", 32'(e_pop.is_err), 32'd0);
          check("done_hold", 32'(cpu_reset_hold), 32'd0);
          check("done_busy", 32'(busy), 32'd0);
        end
      end
      if (err && !err_prev) begin
        if (exp_ev.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_err: got err code %0d expected no event", err_code);
        end else begin
          e_pop = exp_ev.pop_front();
          check("err_event_kind", 32'(e_pop.is_err), 32'd1);
          check("err_code", 32'(err_code), 32'(e_pop.code));
          check("err_hold", 32'(cpu_reset_hold), 32'd1);
          check("err_busy", 32'(busy), 32'd0);
        end
      end
      err_prev = err;
    end else begin
      last_addr = '0;
      last_data = '0;
      err_prev  = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_q(input logic [7:0] q[$], input int gap_max);
    foreach (q[i]) send_byte(q[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Reference model: frame layout and outcome straight from the protocol rules.
  task automatic expect_frame(input int n, input logic [31:0] w[$], input bit corrupt,
                              output logic [7:0] q[$]);
    logic [7:0] c;
    q = {};
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    if (n == 0 || n > DEPTH) begin
      exp_ev.push_back('{1'b1, 2'b01});
      return;
    end
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back('{i[AW-1:0], w[i]});
      for (int k = 0; k < 4; k++) begin
        q.push_back(w[i][8*k +: 8]);
        c ^= w[i][8*k +: 8];
      end
    end
    if (corrupt) begin
      q.push_back(c ^ 8'(1 + $urandom_range(254, 0)));
      exp_ev.push_back('{1'b1, 2'b10});
    end else begin
      q.push_back(c);
      exp_ev.push_back('{1'b0, 2'b00});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0]  fq[$];
  logic [31:0] wq[$];
  logic [7:0]  good[$];
  logic [31:0] word;
  logic [7:0]  c8;
  int          kind;
  int          n;

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_reset_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'({err, err_code}), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Directed good frame with per-byte hold/busy checks.
    good = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'hD0, 8'h0A, 8'hB7, 8'h07, 8'h00, 8'h40, 8'hB9};
    exp_wr.push_back('{6'd0, 32'h0AD00093});
    exp_wr.push_back('{6'd1, 32'h400007B7});
    exp_ev.push_back('{1'b0, 2'b00});
    for (int i = 0; i < good.size(); i++) begin
      @(negedge clk);
      if (i == 0) check("hold_pre", 32'(cpu_reset_hold), 32'd0);
      else begin
        check("hold_frame", 32'(cpu_reset_hold), 32'd1);
        check("busy_frame", 32'(busy), 32'd1);
      end
      rx_valid = 1'b1;
      rx_data  = good[i];
    end
    idle(3);
    check("good_err", 32'(err), 32'd0);
    check("good_hold_after", 32'(cpu_reset_hold), 32'd0);

    // Bad checksum, then the good frame again clears err.
    fq = good;
    fq[11] = 8'hB8;
    exp_wr.push_back('{6'd0, 32'h0AD00093});
    exp_wr.push_back('{6'd1, 32'h400007B7});
    exp_ev.push_back('{1'b1, 2'b10});
    send_q(fq, 0);
    idle(3);
    check("chk_err", 32'(err), 32'd1);
    check("chk_code", 32'(err_code), 32'd2);
    check("chk_hold", 32'(cpu_reset_hold), 32'd1);
    exp_wr.push_back('{6'd0, 32'h0AD00093});
    exp_wr.push_back('{6'd1, 32'h400007B7});
    exp_ev.push_back('{1'b0, 2'b00});
    send_q(good, 0);
    idle(3);
    check("recover_err", 32'(err), 32'd0);

    // Length errors.
    wq = {};
    expect_frame(0, wq, 1'b0, fq);
    send_q(fq, 0);
    idle(3);
    check("len0_code", 32'(err_code), 32'd1);
    expect_frame(65, wq, 1'b0, fq);
    send_q(fq, 0);
    idle(3);
    check("len65_code", 32'(err_code), 32'd1);

    // Full memory load.
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    expect_frame(DEPTH, wq, 1'b0, fq);
    send_q(fq, 0);
    idle(3);
    check("full_last_addr", 32'(mem_waddr), 32'd63);
    check("full_err", 32'(err), 32'd0);

    // Stall after two payload bytes: timeout lands exactly TMO cycles later.
    exp_ev.push_back('{1'b1, 2'b11});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0);
    repeat (TMO) begin @(negedge clk); rx_valid = 1'b0; end
    check("tmo_early", 32'(err), 32'd0);
    @(negedge clk);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_code", 32'(err_code), 32'd3);
    idle(2);

    // Byte on the expiry cycle is accepted.
    word = $urandom;
    c8 = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
    exp_wr.push_back('{6'd0, word});
    exp_ev.push_back('{1'b0, 2'b00});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(word[7:0], 0); send_byte(word[15:8], TMO - 1);
    send_byte(word[23:16], 0); send_byte(word[31:24], 0); send_byte(c8, 0);
    idle(3);
    check("expiry_err", 32'(err), 32'd0);

    // Noise in IDLE.
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h13, 0);
    idle(3);
    check("noise_busy", 32'(busy), 32'd0);
    check("noise_hold", 32'(cpu_reset_hold), 32'd0);
    check("noise_err", 32'(err), 32'd0);

    // Asynchronous reset mid-DATA.
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_hold", 32'(cpu_reset_hold), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_waddr", 32'(mem_waddr), 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
    idle(5);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Randomized frames with noise and gaps.
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(3, 0)) begin
        c8 = 8'($urandom);
        if (c8 == 8'hA5) c8 = 8'h5A;
        send_byte(c8, 0);
      end
      kind = $urandom_range(9, 0);
      n    = (kind == 0) ? 0 : (kind == 1) ? int'($urandom_range(65535, 65)) : int'($urandom_range(6, 1));
      wq = {};
      if (kind > 1) for (int i = 0; i < n; i++) wq.push_back($urandom);
      expect_frame(n, wq, (kind == 2 || kind == 3), fq);
      send_q(fq, 3);
      idle(3);
    end

    idle(5);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("ev_queue_empty", 32'(exp_ev.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Loads RISC-V program words into the 64-word instruction memory at run time from a byte stream, normally the UART RX path.
- Frames a simple load protocol, packs bytes into little-endian 32-bit words and drives the instruction-memory write port.
- Holds the CPU core in reset while a load is in progress.
- Sits between the UART receiver, the instruction memory write port, and the core reset logic.

Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words.
- TIMEOUT_CYC, 100000, maximum idle clocks allowed between bytes once a frame has started.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- mem_we  output  1  instruction memory write enable, one-cycle pulse
- mem_waddr  output  ADDR_WIDTH  word address; byte address = mem_waddr<<2
- mem_wdata  output  32  instruction word
- cpu_reset_hold  output  1  while high, the core is held in reset
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse on successful load
- err  output  1  sticky error flag
- err_code  output  2  01 bad length, 10 checksum mismatch, 11 timeout

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs are 0, state is IDLE, and all counters and the checksum are 0.
- Frame format:
  - Sync byte 0xA5.
  - LEN_LO, LEN_HI: word count N, little-endian 16-bit.
  - 4*N payload bytes.
  - CHK: XOR of all payload bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
  - IDLE: rx_valid with rx_data==0xA5 goes to LEN_LO. All other bytes are ignored.
  - On sync acceptance: clear err, err_code, checksum, word index and byte index. Assert busy and cpu_reset_hold from the next cycle.
  - LEN_LO: capture the low byte, go to LEN_HI.
  - LEN_HI: capture the high byte.
    - If N==0 or N>DEPTH, go to ERR with code 01.
    - Otherwise go to DATA.
  - DATA: byte k (k=0..3) goes to word bits [8k+7:8k].
    - Every payload byte is XORed into the checksum.
    - On the 4th byte: the next cycle has mem_we=1, mem_waddr=word index and mem_wdata=the assembled word. The word index then increments.
    - After word N-1 is accepted, go to CHK.
  - CHK: a byte equal to the checksum goes to DONE; otherwise go to ERR with code 10.
  - DONE: lasts one cycle. done=1 and cpu_reset_hold=0 this cycle, busy=0. Next state is IDLE.
  - ERR: err=1 with err_code held. cpu_reset_hold stays 1 and busy=0. Only a 0xA5 byte leaves ERR, by restarting the frame exactly as IDLE does.
- Timeout:
  - A counter runs in LEN_LO, LEN_HI, DATA and CHK. It is cleared on every rx_valid.
  - Reaching TIMEOUT_CYC goes to ERR with code 11.
  - An rx_valid in the same cycle as expiry wins, and the byte is processed.
- Throughput: rx_valid may occur on every cycle with no bytes dropped. A write pulse never overlaps the next word's assembly incorrectly; mem_wdata is registered.
- A 0xA5 byte inside LEN, DATA or CHK is treated as data, not as a resync.
- Words already written before an error remain in memory; there is no rollback.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- Asynchronous reset mid-frame returns immediately to the reset values. cpu_reset_hold drops to 0, and the core then runs whatever the memory holds.
- The word index is ADDR_WIDTH+1 bits wide, so the comparison against N is exact at N=DEPTH.

Decomposition:
- Shared package imem_loader_pkg: SYNC_BYTE=8'hA5, state encoding, ERR_LEN/ERR_CHK/ERR_TIMEOUT codes.
- One sub-module, byte_word_packer: byte index, shift-in, 4th-byte strobe, registered word output.
- FSM, timeout counter and checksum live in the top module.

Test Plan:
- Good frame: A5 02 00 93 00 D0 0A B7 07 00 40 B9 sent back-to-back.
  - Required: mem_we pulses at addr 0 with 0x0AD00093 and at addr 1 with 0x400007B7.
  - Required: done pulses once, err=0, cpu_reset_hold high from the cycle after A5 through the CHK byte, then 0.
- Same frame with checksum 0xB8: both words are written, then err=1, err_code=10 and cpu_reset_hold stays 1. A following valid frame clears err and completes.
- Length errors:
  - A5 00 00 gives err_code=01 with no mem_we.
  - A5 41 00 (N=65) gives err_code=01.
  - A5 40 00 with 64 words and the correct checksum writes addr 63 last and completes.
- Stall: with TIMEOUT_CYC=50, stop after 2 payload bytes; err_code=11 exactly 50 cycles after the last rx_valid. With a byte arriving on the expiry cycle, the byte is accepted and there is no error.
- Noise and reset:
  - Bytes 00 FF 13 in IDLE produce no state change.
  - reset_n low during DATA: all outputs go to 0 asynchronously, with no mem_we after release until a new A5.
